// File: rtl/pwm_motor_pkg.sv
// pwm_motor_pkg
//   Shared definitions for the PWM motor driver:
//     - bridge direction encodings (DIR_COAST / DIR_FWD / DIR_REV / DIR_BRAKE)
//     - per-channel FSM state enum (ST_RUN, ST_DEAD)
//     - RAMP_EN: 1 when the build defines PWM_RAMP_EN (duty slew limiting)
//     - dir_pair(): maps a channel's direction and state onto its bridge pin pair
package pwm_motor_pkg;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } ch_state_e;

`ifdef PWM_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    // Bridge pins follow the direction code directly; during dead time both
    // legs are released so neither high side conducts.
    function automatic logic [1:0] dir_pair(input logic [1:0] dir, input ch_state_e st);
        return (st == ST_DEAD) ? 2'b00 : dir;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
//   One motor channel: pending (double-buffered) duty/dir, active duty/dir,
//   RUN/DEAD FSM with dead-time counter, optional duty ramp, and the PWM compare.
//   Optional feature macro: PWM_RAMP_EN (duty moves by at most RAMP_STEP per period).
// Ports
//   clk, rst     clock, synchronous active-high reset
//   apply        high on the last cycle of a period (cnt == PERIOD-1)
//   wr_en        write pending duty/dir this cycle
//   wr_duty      duty to write (clk cycles high per period)
//   wr_dir       direction to write (00 coast, 01 fwd, 10 rev, 11 brake)
//   cnt          shared period counter
//   pwm_o        registered PWM enable
//   dir_o        registered bridge pin pair
//   state_o      current FSM state (debug and cmd_ready gating)
module pwm_channel
    import pwm_motor_pkg::*;
#(
    parameter int DW        = 17,
    parameter int DEAD_CYC  = 1000,
    parameter int RAMP_STEP = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          apply,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_duty,
    input  logic [1:0]    wr_dir,
    input  logic [DW-1:0] cnt,
    output logic          pwm_o,
    output logic [1:0]    dir_o,
    output ch_state_e     state_o
);

    localparam int DCW  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    // Without ramping the step is larger than any duty, so one apply reaches the target.
    localparam int STEP = RAMP_EN ? RAMP_STEP : (1 << DW);

    logic [DW-1:0]  pend_duty_q, pend_duty_d;
    logic [1:0]     pend_dir_q, pend_dir_d;
    logic [DW-1:0]  duty_act_q, duty_act_d;
    logic [1:0]     dir_act_q, dir_act_d;
    ch_state_e      state_q, state_d;
    logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
    logic           pwm_q, pwm_d;
    logic [1:0]     dir_q, dir_d;
    logic           reversal;

    // Saturating move of cur toward tgt by at most STEP; never overshoots.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
        int c;
        int t;
        int r;
        c = int'(cur);
        t = int'(tgt);
        if (t > c) r = ((t - c) > STEP) ? (c + STEP) : t;
        else       r = ((c - t) > STEP) ? (c - STEP) : t;
        return DW'(r);
    endfunction

    always_comb begin
        // A write on the apply cycle itself bypasses into the apply decision.
        pend_duty_d = wr_en ? wr_duty : pend_duty_q;
        pend_dir_d  = wr_en ? wr_dir  : pend_dir_q;
        duty_act_d  = duty_act_q;
        dir_act_d   = dir_act_q;
        state_d     = state_q;
        dead_cnt_d  = dead_cnt_q;
        reversal    = ((dir_act_q == DIR_FWD) && (pend_dir_d == DIR_REV)) ||
                      ((dir_act_q == DIR_REV) && (pend_dir_d == DIR_FWD));
        case (state_q)
            ST_RUN: begin
                if (apply) begin
                    if (reversal) begin
                        // With ramping, slow to zero in the old direction before coasting.
                        if (RAMP_EN && (duty_act_q != '0)) begin
                            duty_act_d = step_toward(duty_act_q, '0);
                        end else begin
                            state_d    = ST_DEAD;
                            dead_cnt_d = DCW'(DEAD_CYC - 1);
                        end
                    end else begin
                        dir_act_d  = pend_dir_d;
                        duty_act_d = step_toward(duty_act_q, pend_duty_d);
                    end
                end
            end
            ST_DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d    = ST_RUN;
                    dir_act_d  = pend_dir_d;
                    duty_act_d = step_toward('0, pend_duty_d);
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        pwm_d = (state_q == ST_RUN) && (dir_act_q != DIR_BRAKE) && (cnt < duty_act_q);
        dir_d = dir_pair(dir_act_q, state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_duty_q <= '0;
            pend_dir_q  <= DIR_COAST;
            duty_act_q  <= '0;
            dir_act_q   <= DIR_COAST;
            state_q     <= ST_RUN;
            dead_cnt_q  <= '0;
            pwm_q       <= 1'b0;
            dir_q       <= 2'b00;
        end else begin
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            duty_act_q  <= duty_act_d;
            dir_act_q   <= dir_act_d;
            state_q     <= state_d;
            dead_cnt_q  <= dead_cnt_d;
            pwm_q       <= pwm_d;
            dir_q       <= dir_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign dir_o   = dir_q;
    assign state_o = state_q;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// pwm_motor_ctrl
//   N-channel PWM motor driver between line-tracking logic and H-bridge pins.
//   Owns the shared period counter, period_start pulse, command decode and the
//   cmd_ready mux; each channel is a pwm_channel instance.
//   Optional feature macro: PWM_RAMP_EN (duty ramp limited to RAMP_STEP per period).
// Handshake: a command transfers on any cycle where cmd_valid && cmd_ready.
//   cmd_ready is low during rst and while the channel selected by cmd_ch is in
//   dead time; out-of-range cmd_ch is accepted and discarded.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cmd_valid/ready command handshake
//   cmd_ch         target channel
//   cmd_duty       high time in clk cycles per period
//   cmd_dir        00 coast, 01 fwd, 10 rev, 11 brake
//   pwm_out        PWM enable per channel
//   dir_out        bridge pin pair per channel, pair i = [2i+1:2i]
//   period_start   one-cycle pulse for the counter==0 cycle
module pwm_motor_ctrl
    import pwm_motor_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int PERIOD    = 100000,
    parameter int DW        = 17,
    parameter int DEAD_CYC  = 1000,
    parameter int RAMP_STEP = 1000,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CHW-1:0]   cmd_ch,
    input  logic [DW-1:0]    cmd_duty,
    input  logic [1:0]       cmd_dir,
    output logic [NCH-1:0]   pwm_out,
    output logic [2*NCH-1:0] dir_out,
    output logic             period_start
);

    logic [DW-1:0]  cnt_q, cnt_d;
    logic           period_start_q, period_start_d;
    logic           apply;
    logic           ch_dead;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] dead;

    always_comb begin
        apply          = (cnt_q == DW'(PERIOD - 1));
        cnt_d          = apply ? '0 : (cnt_q + 1'b1);
        period_start_d = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    // Only the addressed channel's dead time blocks the port.
    always_comb begin
        ch_dead = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if ((cmd_ch == CHW'(i)) && dead[i]) ch_dead = 1'b1;
        end
    end

    assign cmd_ready = ~rst & ~ch_dead;

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_en[i] = cmd_valid && cmd_ready && (cmd_ch == CHW'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ch_state_e st;
        pwm_channel #(
            .DW        (DW),
            .DEAD_CYC  (DEAD_CYC),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .apply   (apply),
            .wr_en   (wr_en[g]),
            .wr_duty (cmd_duty),
            .wr_dir  (cmd_dir),
            .cnt     (cnt_q),
            .pwm_o   (pwm_out[g]),
            .dir_o   (dir_out[2*g+1:2*g]),
            .state_o (st)
        );
        assign dead[g] = (st == ST_DEAD);
    end

    assign period_start = period_start_q;

endmodule
